dm_port_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: M0 is the CPU load/store path and M1 is a debug/DMA port.
- Arbitrates requests, sequences each access onto the memory port and returns read data to the winner.
- The memory port uses word addresses (bits [31:2]) and a write enable; reads are registered, with data valid the cycle after the address edge.
- The block sits between the requesters and the data memory and is the only driver of the memory port.

---
 rtl/dm_port_arbiter.sv | 102 ++++++++++
 tb/tb_dm_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for the single-port data memory.
// M0 is the CPU load/store path, M1 the debug/DMA port.
module dm_port_arbiter #(
  parameter int AW    = 30,
  parameter int DW    = 32,
  parameter int RR_EN = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_wrdata,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_dm,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state;
  logic          owner;
  logic          last_grant;
  logic          win;
  logic          any_req;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  // win: 0 = M0, 1 = M1
  always_comb begin
    any_req = m0_req | m1_req;
    win     = 1'b0;
    if (m0_req && m1_req)
      win = (RR_EN != 0) ? ~last_grant : 1'b0;
    else if (m1_req)
      win = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      mem_ad     <= '0;
      mem_wrdata <= '0;
      mem_wr     <= 1'b0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= win;
            last_grant <= win;
            mem_ad     <= win ? m1_addr : m0_addr;
            mem_wrdata <= win ? m1_wdata : m0_wdata;
            mem_wr     <= win ? m1_we : m0_we;
            m0_gnt     <= ~win;
            m1_gnt     <= win;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          mem_wr <= 1'b0;
          state  <= mem_wr ? IDLE : RESP;
        end
        RESP: begin
          // keep the delivered word so rdata holds after rvalid
          if (owner) rdata1_q <= mem_dm;
          else       rdata0_q <= mem_dm;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_rvalid = (state == RESP) && !owner;
  assign m1_rvalid = (state == RESP) && owner;
  assign m0_rdata  = m0_rvalid ? mem_dm : rdata0_q;
  assign m1_rdata  = m1_rvalid ? mem_dm : rdata1_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: memory model plus
// scoreboard queues of expected read data and grant order.
module tb_dm_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [29:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [29:0] mem_ad;
  logic [31:0] mem_wrdata, mem_dm;
  logic        mem_wr, busy;

  logic        f0_req = 0, f1_req = 0;
  logic        f0_gnt, f0_rvalid, f1_gnt, f1_rvalid;
  logic [31:0] f0_rdata, f1_rdata, f_wrdata, f_mem_dm;
  logic [29:0] f_ad;
  logic        f_wr, f_busy;

  logic [31:0] mem [0:63];
  logic        pre_we = 0;
  logic [5:0]  pre_a = '0;
  logic [31:0] pre_d = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q [$];
  int          gnt_q [$];

  always #5 Clk = ~Clk;

  assign f_mem_dm = 32'h0;

  always @(posedge Clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_wr) mem[mem_ad[5:0]] <= mem_wrdata;
    mem_dm <= mem[mem_ad[5:0]];
  end

  dm_port_arbiter #(.AW(30), .DW(32), .RR_EN(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_ad(mem_ad), .mem_wrdata(mem_wrdata),
    .mem_wr(mem_wr), .mem_dm(mem_dm), .busy(busy)
  );

  dm_port_arbiter #(.AW(30), .DW(32), .RR_EN(0)) dut_fp (
    .Clk(Clk), .Reset(Reset),
    .m0_req(f0_req), .m0_we(1'b0), .m0_addr(30'd1),
    .m0_wdata(32'h0), .m0_gnt(f0_gnt),
    .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata),
    .m1_req(f1_req), .m1_we(1'b0), .m1_addr(30'd2),
    .m1_wdata(32'h0), .m1_gnt(f1_gnt),
    .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata),
    .mem_ad(f_ad), .mem_wrdata(f_wrdata),
    .mem_wr(f_wr), .mem_dm(f_mem_dm), .busy(f_busy)
  );

  task automatic poke(input logic [5:0] a, input logic [31:0] d);
    pre_we = 1; pre_a = a; pre_d = d;
    @(negedge Clk);
    pre_we = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    poke(6'd3, 32'hDEADBEEF);
    poke(6'd7, 32'h77777777);
    poke(6'd10, 32'h0000_0A0A);
    poke(6'd11, 32'h0000_0B0B);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
        {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr, busy});
    end
    checks++;
    if (mem_ad !== 30'd0 || mem_wrdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem got ad=%h wd=%h want 0", mem_ad, mem_wrdata);
    end
    checks++;
    if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h want 0", m0_rdata, m1_rdata);
    end
    Reset = 0;
    @(negedge Clk);
  endtask

  task automatic test_m0_read();
    logic [31:0] exp;
    m0_req = 1; m0_we = 0; m0_addr = 30'd3;
    rd_q.push_back(32'hDEADBEEF);
    @(negedge Clk);
    checks++;
    if ({m0_gnt, m1_gnt, busy} !== 3'b101 || mem_ad !== 30'd3) begin
      errors++;
      $display("FAIL m0rd_gnt got gnt/gnt1/busy=%b ad=%h want 101 ad=3",
        {m0_gnt, m1_gnt, busy}, mem_ad);
    end
    m0_req = 0;
    @(negedge Clk);
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_gnt, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL m0rd_rvalid got %b want 1001",
        {m0_rvalid, m1_rvalid, m0_gnt, busy});
    end
    exp = rd_q.pop_front();
    checks++;
    if (m0_rdata !== exp) begin
      errors++;
      $display("FAIL m0rd_data got %h want %h", m0_rdata, exp);
    end
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || m0_rvalid !== 1'b0 || m0_rdata !== exp) begin
      errors++;
      $display("FAIL m0rd_after got busy=%b rv=%b d=%h want 0 0 %h",
        busy, m0_rvalid, m0_rdata, exp);
    end
  endtask

  task automatic test_m1_write_read();
    logic [31:0] exp;
    bit got;
    m1_req = 1; m1_we = 1; m1_addr = 30'd5; m1_wdata = 32'h12345678;
    @(negedge Clk);
    checks++;
    if ({m1_gnt, mem_wr, m0_gnt} !== 3'b110 || mem_wrdata !== 32'h12345678) begin
      errors++;
      $display("FAIL m1wr_gnt got %b wd=%h want 110 12345678",
        {m1_gnt, mem_wr, m0_gnt}, mem_wrdata);
    end
    m1_req = 0;
    @(negedge Clk);
    checks++;
    if (mem_wr !== 1'b0 || busy !== 1'b0 || mem[5] !== 32'h12345678) begin
      errors++;
      $display("FAIL m1wr_done got wr=%b busy=%b mem5=%h want 0 0 12345678",
        mem_wr, busy, mem[5]);
    end
    m1_req = 1; m1_we = 0; m1_addr = 30'd5;
    rd_q.push_back(32'h12345678);
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge Clk);
      if (m1_gnt) m1_req = 0;
      if (m0_gnt || m0_rvalid) begin
        checks++; errors++;
        $display("FAIL m1rd_m0quiet got m0 gnt/rvalid=%b%b want 00",
          m0_gnt, m0_rvalid);
      end
      if (m1_rvalid) begin
        got = 1;
        exp = rd_q.pop_front();
        checks++;
        if (m1_rdata !== exp) begin
          errors++;
          $display("FAIL m1rd_data got %h want %h", m1_rdata, exp);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL m1rd_timeout got no rvalid want rvalid");
    end
    m1_req = 0;
    @(negedge Clk);
  endtask

  task automatic test_round_robin();
    int e;
    gnt_q = {0, 1, 0, 1};
    m0_req = 1; m0_we = 0; m0_addr = 30'd10;
    m1_req = 1; m1_we = 0; m1_addr = 30'd11;
    for (int c = 0; c < 40 && gnt_q.size() > 0; c++) begin
      @(negedge Clk);
      if (m0_gnt || m1_gnt) begin
        e = gnt_q.pop_front();
        checks++;
        if ((m0_gnt && m1_gnt) || int'(m1_gnt) != e) begin
          errors++;
          $display("FAIL rr_order got m0=%b m1=%b want port %0d",
            m0_gnt, m1_gnt, e);
        end
      end
    end
    if (gnt_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rr_timeout got %0d grants missing want 0", gnt_q.size());
      gnt_q.delete();
    end
    m0_req = 0; m1_req = 0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_fixed_priority();
    int e;
    gnt_q = {0, 0, 0, 0};
    f0_req = 1; f1_req = 1;
    for (int c = 0; c < 40 && gnt_q.size() > 0; c++) begin
      @(negedge Clk);
      if (f0_gnt || f1_gnt) begin
        e = gnt_q.pop_front();
        checks++;
        if ((f0_gnt && f1_gnt) || int'(f1_gnt) != e) begin
          errors++;
          $display("FAIL fp_order got m0=%b m1=%b want port %0d",
            f0_gnt, f1_gnt, e);
        end
      end
    end
    if (gnt_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL fp_timeout got %0d grants missing want 0", gnt_q.size());
      gnt_q.delete();
    end
    f0_req = 0; f1_req = 0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_contention();
    logic [31:0] exp;
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    m0_req = 1; m0_we = 1; m0_addr = 30'd8; m0_wdata = 32'hAAAA5555;
    m1_req = 1; m1_we = 0; m1_addr = 30'd5;
    rd_q.push_back(32'h12345678);
    @(negedge Clk);
    checks++;
    if ({m0_gnt, m1_gnt, mem_wr} !== 3'b101) begin
      errors++;
      $display("FAIL cont_first got %b want 101", {m0_gnt, m1_gnt, mem_wr});
    end
    m0_req = 0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || m1_gnt !== 1'b0 || mem[8] !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL cont_wrdone got busy=%b g1=%b mem8=%h want 0 0 aaaa5555",
        busy, m1_gnt, mem[8]);
    end
    @(negedge Clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL cont_second got %b want 01", {m0_gnt, m1_gnt});
    end
    m1_req = 0;
    @(negedge Clk);
    exp = rd_q.pop_front();
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== exp) begin
      errors++;
      $display("FAIL cont_rdata got rv=%b d=%h want 1 %h",
        m1_rvalid, m1_rdata, exp);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_write();
    logic [31:0] exp;
    bit got;
    m1_req = 1; m1_we = 1; m1_addr = 30'd7; m1_wdata = 32'hBAD0BAD0;
    @(negedge Clk);
    m1_req = 0;
    checks++;
    if ({m1_gnt, mem_wr} !== 2'b11) begin
      errors++;
      $display("FAIL rstwr_access got %b want 11", {m1_gnt, mem_wr});
    end
    #2 Reset = 1;
    #1;
    checks++;
    if ({mem_wr, m1_gnt, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rstwr_async got %b want 000", {mem_wr, m1_gnt, busy});
    end
    @(negedge Clk);
    Reset = 0;
    checks++;
    if (mem[7] !== 32'h77777777) begin
      errors++;
      $display("FAIL rstwr_mem got %h want 77777777", mem[7]);
    end
    repeat (3) begin
      @(negedge Clk);
      checks++;
      if ({m1_gnt, m1_rvalid, busy} !== 3'b000) begin
        errors++;
        $display("FAIL rstwr_quiet got %b want 000", {m1_gnt, m1_rvalid, busy});
      end
    end
    m0_req = 1; m0_we = 0; m0_addr = 30'd3;
    rd_q.push_back(32'hDEADBEEF);
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge Clk);
      if (m0_gnt) m0_req = 0;
      if (m0_rvalid) begin
        got = 1;
        exp = rd_q.pop_front();
        checks++;
        if (m0_rdata !== exp) begin
          errors++;
          $display("FAIL rstwr_next got %h want %h", m0_rdata, exp);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rstwr_timeout got no rvalid want rvalid");
    end
    m0_req = 0;
    @(negedge Clk);
  endtask

  task automatic test_reset_resp();
    logic [31:0] exp;
    m0_req = 1; m0_we = 0; m0_addr = 30'd3;
    @(negedge Clk);
    m0_req = 0;
    @(negedge Clk);
    checks++;
    if (m0_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstrsp_resp got rv=%b want 1", m0_rvalid);
    end
    #2 Reset = 1;
    #1;
    checks++;
    if ({m0_rvalid, busy} !== 2'b00 || m0_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rstrsp_async got rv/busy=%b d=%h want 00 0",
        {m0_rvalid, busy}, m0_rdata);
    end
    @(negedge Clk);
    Reset = 0;
    m1_req = 1; m1_we = 0; m1_addr = 30'd5;
    rd_q.push_back(32'h12345678);
    @(negedge Clk);
    m1_req = 0;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rstrsp_m1gnt got %b want 01", {m0_gnt, m1_gnt});
    end
    @(negedge Clk);
    exp = rd_q.pop_front();
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== exp) begin
      errors++;
      $display("FAIL rstrsp_m1data got rv=%b d=%h want 1 %h",
        m1_rvalid, m1_rdata, exp);
    end
    @(negedge Clk);
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_m0_read();
    test_m1_write_read();
    test_round_robin();
    test_fixed_priority();
    test_contention();
    test_reset_write();
    test_reset_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
